pipeline_fwd_ctrl: RTL

PIPELINE_FWD_CTRL -- requirements
Module: pipeline_fwd_ctrl

---
 rtl/pipeline_fwd_ctrl_pkg.sv | 13 +
 rtl/pipeline_fwd_sel.sv | 31 +++
 rtl/pipeline_fwd_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/pipeline_fwd_ctrl_pkg.sv
// rtl/pipeline_fwd_ctrl_pkg.sv - shared CPU forwarding encodings and datapath widths
package pipeline_fwd_ctrl_pkg;

    localparam int CPU_DW = 32;
    localparam int CPU_RW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/pipeline_fwd_sel.sv
// rtl/pipeline_fwd_sel.sv - per-operand forwarding source compare
module pipeline_fwd_sel
    import pipeline_fwd_ctrl_pkg::*;
#(
    parameter int RW = CPU_RW
) (
    input  logic [RW-1:0] src,
    input  logic [RW-1:0] mem_rd,
    input  logic          mem_reg_write,
    input  logic [RW-1:0] wb_rd,
    input  logic          wb_reg_write,
    output logic [1:0]    sel
);

    logic mem_hit;
    logic wb_hit;

    // Register 0 is hard-wired, so a write to it must never be forwarded.
    assign mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == src);
    assign wb_hit  = wb_reg_write && (wb_rd != '0) && (wb_rd == src);

    always_comb begin
        sel = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_fwd_ctrl.sv
// rtl/pipeline_fwd_ctrl.sv - EX/MEM and MEM/WB registers with forwarding and load-use stall
module pipeline_fwd_ctrl
    import pipeline_fwd_ctrl_pkg::*;
#(
    parameter int DW = CPU_DW,
    parameter int RW = CPU_RW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [RW-1:0] ID_rs,
    input  logic [RW-1:0] ID_rt,
    input  logic [RW-1:0] EX_rs,
    input  logic [RW-1:0] EX_rt,
    input  logic [RW-1:0] EX_Rd,
    input  logic          EX_RegWrite,
    input  logic          EX_MemRead,
    input  logic          EX_MemtoReg,
    input  logic          EX_Flush,
    input  logic [DW-1:0] EX_ALUOut,
    input  logic [DW-1:0] MEM_ReadData,
    output logic [1:0]    ForwardA,
    output logic [1:0]    ForwardB,
    output logic [DW-1:0] EXMEMdata,
    output logic [DW-1:0] MEMWBdata,
    output logic          Stall,
    output logic [RW-1:0] MEM_Rd,
    output logic          MEM_RegWrite,
    output logic          MEM_MemRead,
    output logic [RW-1:0] WB_Rd,
    output logic          WB_RegWrite
);

    logic [DW-1:0] mem_data;
    logic          mem_memtoreg;
    logic [DW-1:0] wb_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_data     <= '0;
            MEM_Rd       <= '0;
            MEM_RegWrite <= 1'b0;
            MEM_MemRead  <= 1'b0;
            mem_memtoreg <= 1'b0;
            wb_data      <= '0;
            WB_Rd        <= '0;
            WB_RegWrite  <= 1'b0;
        end else begin
            // A flushed instruction keeps its data/Rd but loses every side effect.
            mem_data     <= EX_ALUOut;
            MEM_Rd       <= EX_Rd;
            MEM_RegWrite <= EX_RegWrite & ~EX_Flush;
            MEM_MemRead  <= EX_MemRead & ~EX_Flush;
            mem_memtoreg <= EX_MemtoReg & ~EX_Flush;
            wb_data      <= mem_memtoreg ? MEM_ReadData : mem_data;
            WB_Rd        <= MEM_Rd;
            WB_RegWrite  <= MEM_RegWrite;
        end
    end

    assign EXMEMdata = mem_data;
    assign MEMWBdata = wb_data;

    pipeline_fwd_sel #(.RW(RW)) u_sel_rs (
        .src           (EX_rs),
        .mem_rd        (MEM_Rd),
        .mem_reg_write (MEM_RegWrite),
        .wb_rd         (WB_Rd),
        .wb_reg_write  (WB_RegWrite),
        .sel           (ForwardA)
    );

    pipeline_fwd_sel #(.RW(RW)) u_sel_rt (
        .src           (EX_rt),
        .mem_rd        (MEM_Rd),
        .mem_reg_write (MEM_RegWrite),
        .wb_rd         (WB_Rd),
        .wb_reg_write  (WB_RegWrite),
        .sel           (ForwardB)
    );

    // Gated by reset so a load sitting on the EX inputs cannot stall during reset.
    assign Stall = reset && !EX_Flush && EX_MemRead && EX_RegWrite && (EX_Rd != '0)
                   && ((EX_Rd == ID_rs) || (EX_Rd == ID_rt));

endmodule
